pcd8544_responder: RTL and testbench
====================================

# pcd8544_responder

- SPI responder that models the PCD8544 (Nokia 5110) display controller at the far end of the link driven by `spi_master`.
- Samples MOSI/SCLK/SCE/DC/RST in the system clock domain, assembles bytes and decodes commands, writing data bytes into a 504-byte frame buffer (84 columns × 6 banks).
- Used as the on-chip bench/loopback model for the LCD path.
- Exposes a read port into the frame buffer so a display scanner can show what the driver actually sent.

## Interface
Parameters:
- `FB_COLS`, default 84: number of X addresses.
- `FB_BANKS`, default 6: number of Y banks.

Ports:
- `clock`, input, 1: system clock.
- `Reset`, input, 1: asynchronous, active-low reset.
- `sclk`, input, 1: SPI clock from master; idles low; data is captured on its rising edge.
- `mosi`, input, 1: serial data, MSB first.
- `sce`, input, 1: chip enable, active low.
- `dc`, input, 1: 0 = command, 1 = data; sampled together with bit 0 of the byte.
- `rst`, input, 1: LCD reset, active low. Synchronous to `clock` after synchronization.
- `rd_addr`, input, 9: frame buffer read address, 0..503.
- `rd_data`, output, 8: frame buffer read data; 1-cycle latency.
- `byte_valid`, output, 1: one-cycle pulse for each completed byte.
- `byte_data`, output, 8: last completed byte.
- `byte_dc`, output, 1: DC value of the last completed byte.
- `pd`, output, 1: power-down bit.
- `v_mode`, output, 1: 1 = vertical addressing.
- `h_ext`, output, 1: extended instruction set selected.
- `disp_mode`, output, 2: `{D,E}` from the display-control command.
- `x_addr`, output, 7: current column.
- `y_addr`, output, 3: current bank.
- `vop`, output, 7: contrast setting.
- `tc`, output, 2: temperature coefficient.
- `bias`, output, 3: bias setting.
- `err_addr`, output, 1: sticky flag, set by an out-of-range Set X or Set Y.

## Operation
- **Input synchronization.** `sclk`, `mosi`, `sce`, `dc`, `rst` each pass through a 2-flop synchronizer. A third `sclk` stage provides rising-edge detection.
- **Bit capture.**
  - On a detected rising edge with `sce`=0, shift `mosi` into an 8-bit register and increment the 3-bit bit counter.
  - On the 8th bit, capture `dc`, pulse `byte_valid` and decode the byte.
- **Chip deselect.** While `sce`=1, the bit counter is held at 0, so a partial byte is discarded. Decode state and addresses are kept.
- **Command decode (`dc`=0), H=0:**
  - `0000_0000`: NOP.
  - `0010_0PVH`: function set; loads `pd`, `v_mode`, `h_ext`. This command is decoded in both H modes.
  - `0000_1D0E`: sets `disp_mode`.
  - `0100_0yyy`: Set Y.
  - `1xxx_xxxx`: Set X.
  - Any other byte: ignored.
- **Command decode (`dc`=0), H=1:**
  - `0000_01tt`: sets `tc`.
  - `0001_0bbb`: sets `bias`.
  - `1vvv_vvvv`: sets `vop`.
  - Any other byte (except function set): ignored.
- **Out-of-range addresses.** Set X with value ≥ `FB_COLS`, or Set Y with value ≥ `FB_BANKS`: the address is unchanged and `err_addr` is set. Only `Reset` or `rst` clears `err_addr`.
- **Data (`dc`=1).** Write the byte to frame buffer address `y_addr*FB_COLS + x_addr`, then advance the address:
  - Horizontal (`v_mode`=0): x+1. At x=83, x goes to 0 and y+1; at y=5, y wraps to 0.
  - Vertical (`v_mode`=1): y+1. At y=5, y goes to 0 and x+1; at x=83, x wraps to 0.
  - Data is written regardless of `pd`.
- **LCD reset (`rst`=0, synchronized).** Registers go to their reset values and the bit counter is cleared; frame buffer contents are kept. While `rst`=0, no bytes are captured.

## Timing
- **Reset values:**
  - `pd`=1.
  - `v_mode`, `h_ext`, `disp_mode`, `x_addr`, `y_addr`, `vop`, `tc`, `bias`, `err_addr` = 0.
  - `byte_valid`=0, `byte_data`=0, `byte_dc`=0, `rd_data`=0.
  - Bit counter = 0.
  - `Reset` does not clear the frame buffer.
- **Latency:**
  - `byte_valid` is asserted 3 `clock` cycles after the cycle in which the pin `sclk` first rises for bit 0.
  - The frame buffer write and the address/register update happen on the edge that ends the `byte_valid` cycle.
  - Status outputs are therefore visible 1 cycle after `byte_valid`.
- **Read port.** `rd_data` follows `rd_addr` with 1-cycle registered latency. A read and a write to the same address in the same cycle return the old data.
- **Clock ratio.** Correct operation requires `clock` ≥ 8× SCLK, and SCLK high/low phases ≥ 3 clocks each. `spi_master` with its `div_factor` satisfies this.
- **Mid-operation reset.** `Reset` asserted mid-byte aborts the byte immediately; no write is issued.
- **SCE timing.** `sce` rising in the same cycle as the 8th edge: the byte completes, because the edge is sampled first.

## Configuration
- Macro `PCD8544_RESP_EXT_EN`.
- **Defined:** H=1 commands decode into `vop`, `tc`, `bias`.
- **Undefined:**
  - H=1 command bytes (other than function set) are ignored.
  - `vop`, `tc`, `bias` are tied to 0.
  - `h_ext` still tracks the function-set H bit.

## Structure
- **Shared package `pcd8544_pkg`:**
  - Opcode masks and patterns: `OP_FUNC`, `OP_DISP`, `OP_SETY`, `OP_SETX`, `OP_TC`, `OP_BIAS`, `OP_VOP`.
  - `FB_SIZE`=504.
  - The `disp_mode` encodings (BLANK, NORMAL, ALL_ON, INVERSE).
- **Sub-module `pcd8544_fb`:** simple dual-port 504×8 RAM, with one write port and one registered read port.
- All other logic is in the top module (synchronizers, shifter, decoder, address counters).

## Test plan
- **Init sequence.** Send bytes 0x21, 0x90, 0x20, 0x0C with `dc`=0.
  - Expect `vop`=0x10, `h_ext`=0, `pd`=0, `disp_mode`=2'b10.
  - Expect 4 `byte_valid` pulses.
- **Full-screen fill.** Send 504 data bytes 0xAA, then 1 more byte 0x55.
  - Addresses 1..503 read 0xAA; address 0 reads 0x55.
  - Afterwards `x_addr`=1, `y_addr`=0.
- **Positioned writes.** Commands 0x8E, 0x43, then data 0x1F, 0x1F.
  - Address 266 and address 267 read 0x1F.
  - `x_addr`=16, `y_addr`=3.
- **Vertical mode wrap.** Commands 0x22, 0xD3 (X=83), 0x45, then data 0x01, 0x02.
  - Address 503 reads 0x01; address 0 reads 0x02.
  - `x_addr`=0, `y_addr`=1.
- **Error and abort cases:**
  - Command 0xD8 (X=88): `x_addr` unchanged, `err_addr`=1.
  - 5 bits, then `sce` high, then the byte 0x0D: no partial byte; `disp_mode`=2'b11.
- **Resets:**
  - `rst` low for 4 clocks: all status outputs return to reset values; frame buffer contents kept.
  - `Reset` pulsed mid-byte: no write, and `byte_valid` stays 0.

Source files
------------

// File: rtl/pcd8544_pkg.sv
// Shared constants for the PCD8544 responder: command opcode masks/patterns,
// frame buffer size and display-mode encodings.
package pcd8544_pkg;

  localparam int FB_SIZE = 504;

  localparam logic [7:0] OP_FUNC_MASK = 8'hF8;
  localparam logic [7:0] OP_FUNC      = 8'h20;
  localparam logic [7:0] OP_DISP_MASK = 8'hFA;
  localparam logic [7:0] OP_DISP      = 8'h08;
  localparam logic [7:0] OP_SETY_MASK = 8'hF8;
  localparam logic [7:0] OP_SETY      = 8'h40;
  localparam logic [7:0] OP_SETX_MASK = 8'h80;
  localparam logic [7:0] OP_SETX      = 8'h80;
  localparam logic [7:0] OP_TC_MASK   = 8'hFC;
  localparam logic [7:0] OP_TC        = 8'h04;
  localparam logic [7:0] OP_BIAS_MASK = 8'hF8;
  localparam logic [7:0] OP_BIAS      = 8'h10;
  localparam logic [7:0] OP_VOP_MASK  = 8'h80;
  localparam logic [7:0] OP_VOP       = 8'h80;

  // {D,E} as carried by the display-control command
  typedef enum logic [1:0] {
    DISP_BLANK   = 2'b00,
    DISP_ALL_ON  = 2'b01,
    DISP_NORMAL  = 2'b10,
    DISP_INVERSE = 2'b11
  } disp_mode_e;

  function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                    input logic [7:0] pat);
    return (b & mask) == pat;
  endfunction

endpackage

// File: rtl/pcd8544_fb.sv
// Frame buffer for the PCD8544 responder: one write port, one registered read
// port; a same-address read/write returns the old contents.
module pcd8544_fb
  import pcd8544_pkg::*;
#(
  parameter int DEPTH = FB_SIZE
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       we,
  input  logic [8:0] waddr,
  input  logic [7:0] wdata,
  input  logic [8:0] raddr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads return 0 rather than touching nonexistent storage
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      rd_data <= 8'h00;
    end else if (32'(raddr) < DEPTH) begin
      rd_data <= mem[raddr];
    end else begin
      rd_data <= 8'h00;
    end
  end

endmodule

// File: rtl/pcd8544_responder.sv
// PCD8544 (Nokia 5110) SPI responder model with frame buffer read-back.
// Define PCD8544_RESP_EXT_EN to decode the extended (H=1) vop/tc/bias commands.
module pcd8544_responder
  import pcd8544_pkg::*;
#(
  parameter int FB_COLS  = 84,
  parameter int FB_BANKS = 6
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic       rst,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       pd,
  output logic       v_mode,
  output logic       h_ext,
  output logic [1:0] disp_mode,
  output logic [6:0] x_addr,
  output logic [2:0] y_addr,
  output logic [6:0] vop,
  output logic [1:0] tc,
  output logic [2:0] bias,
  output logic       err_addr
);

  localparam logic [6:0] X_LAST = 7'(FB_COLS - 1);
  localparam logic [2:0] Y_LAST = 3'(FB_BANKS - 1);

  logic [1:0] sclk_sync, mosi_sync, sce_sync, dc_sync, rst_sync;
  logic       sclk_d3, sce_d3;
  logic       sclk_rise, lcd_rst_n;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       fb_we;
  logic [8:0] fb_waddr;

  // sce and rst idle high so leaving Reset does not look like a select or LCD reset
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sce_sync  <= 2'b11;
      dc_sync   <= 2'b00;
      rst_sync  <= 2'b11;
      sclk_d3   <= 1'b0;
      sce_d3    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sce_sync  <= {sce_sync[0], sce};
      dc_sync   <= {dc_sync[0], dc};
      rst_sync  <= {rst_sync[0], rst};
      sclk_d3   <= sclk_sync[1];
      sce_d3    <= sce_sync[1];
    end
  end

  // sce is gated one stage later than the edge so a simultaneous deselect still completes the byte
  assign sclk_rise = sclk_sync[1] & ~sclk_d3;
  assign lcd_rst_n = rst_sync[1];

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else if (!lcd_rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sce_d3) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[5:0], mosi_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_reg, mosi_sync[1]};
          byte_dc    <= dc_sync[1];
        end
      end
    end
  end

  assign fb_waddr = 9'(y_addr) * 9'(FB_COLS) + 9'(x_addr);
  assign fb_we    = byte_valid & byte_dc & lcd_rst_n;

  // Decode runs in the cycle after capture, using the H bit in force before this byte
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      pd        <= 1'b1;
      v_mode    <= 1'b0;
      h_ext     <= 1'b0;
      disp_mode <= DISP_BLANK;
      x_addr    <= '0;
      y_addr    <= '0;
      err_addr  <= 1'b0;
    end else if (!lcd_rst_n) begin
      pd        <= 1'b1;
      v_mode    <= 1'b0;
      h_ext     <= 1'b0;
      disp_mode <= DISP_BLANK;
      x_addr    <= '0;
      y_addr    <= '0;
      err_addr  <= 1'b0;
    end else if (byte_valid && !byte_dc) begin
      if (op_match(byte_data, OP_FUNC_MASK, OP_FUNC)) begin
        pd     <= byte_data[2];
        v_mode <= byte_data[1];
        h_ext  <= byte_data[0];
      end else if (!h_ext) begin
        if (op_match(byte_data, OP_DISP_MASK, OP_DISP)) begin
          disp_mode <= {byte_data[2], byte_data[0]};
        end else if (op_match(byte_data, OP_SETY_MASK, OP_SETY)) begin
          if (byte_data[2:0] > Y_LAST) begin
            err_addr <= 1'b1;
          end else begin
            y_addr <= byte_data[2:0];
          end
        end else if (op_match(byte_data, OP_SETX_MASK, OP_SETX)) begin
          if (byte_data[6:0] > X_LAST) begin
            err_addr <= 1'b1;
          end else begin
            x_addr <= byte_data[6:0];
          end
        end
      end
    end else if (byte_valid && byte_dc) begin
      if (!v_mode) begin
        if (x_addr == X_LAST) begin
          x_addr <= '0;
          y_addr <= (y_addr == Y_LAST) ? 3'd0 : y_addr + 3'd1;
        end else begin
          x_addr <= x_addr + 7'd1;
        end
      end else begin
        if (y_addr == Y_LAST) begin
          y_addr <= '0;
          x_addr <= (x_addr == X_LAST) ? 7'd0 : x_addr + 7'd1;
        end else begin
          y_addr <= y_addr + 3'd1;
        end
      end
    end
  end

`ifdef PCD8544_RESP_EXT_EN
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      vop  <= '0;
      tc   <= '0;
      bias <= '0;
    end else if (!lcd_rst_n) begin
      vop  <= '0;
      tc   <= '0;
      bias <= '0;
    end else if (byte_valid && !byte_dc && h_ext) begin
      if (op_match(byte_data, OP_TC_MASK, OP_TC)) begin
        tc <= byte_data[1:0];
      end else if (op_match(byte_data, OP_BIAS_MASK, OP_BIAS)) begin
        bias <= byte_data[2:0];
      end else if (op_match(byte_data, OP_VOP_MASK, OP_VOP)) begin
        vop <= byte_data[6:0];
      end
    end
  end
`else
  assign vop  = '0;
  assign tc   = '0;
  assign bias = '0;
`endif

  pcd8544_fb #(
    .DEPTH(FB_COLS * FB_BANKS)
  ) u_fb (
    .clock  (clock),
    .Reset  (Reset),
    .we     (fb_we),
    .waddr  (fb_waddr),
    .wdata  (byte_data),
    .raddr  (rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_pcd8544_responder.sv
// Directed self-checking bench for pcd8544_responder: init, fill, positioning,
// vertical wrap, address errors, partial-byte abort, LCD reset and Reset abort.
module tb_pcd8544_responder;

  localparam int HALF = 4;

  logic       clock;
  logic       Reset;
  logic       sclk, mosi, sce, dc, rst;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       pd, v_mode, h_ext;
  logic [1:0] disp_mode;
  logic [6:0] x_addr;
  logic [2:0] y_addr;
  logic [6:0] vop;
  logic [1:0] tc;
  logic [2:0] bias;
  logic       err_addr;

  int compared = 0;
  int mismatched = 0;
  int pulse_cnt = 0;

  logic [27:0] status;
  localparam logic [27:0] STATUS_RESET = {1'b1, 27'd0};

  logic [6:0] exp_vop;

  assign status = {pd, v_mode, h_ext, disp_mode, x_addr, y_addr, vop, tc, bias, err_addr};

  pcd8544_responder dut (
    .clock     (clock),
    .Reset     (Reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .sce       (sce),
    .dc        (dc),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .pd        (pd),
    .v_mode    (v_mode),
    .h_ext     (h_ext),
    .disp_mode (disp_mode),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .vop       (vop),
    .tc        (tc),
    .bias      (bias),
    .err_addr  (err_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (byte_valid === 1'b1) pulse_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic dcv);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      dc = dcv;
      repeat (HALF) @(negedge clock);
      sclk = 1'b1;
      repeat (HALF) @(negedge clock);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    sce = 1'b0;
    send_bits(b, 8, dcv);
    repeat (4) @(negedge clock);
  endtask

  task automatic read_fb(input logic [8:0] a, output logic [7:0] d);
    @(negedge clock);
    rd_addr = a;
    @(negedge clock);
    d = rd_data;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    sclk = 1'b0; mosi = 1'b0; sce = 1'b1; dc = 1'b0; rst = 1'b1; rd_addr = '0;
    repeat (3) @(negedge clock);
    compared++;
    if (status !== STATUS_RESET) begin
      mismatched++;
      $display("[TB] FAIL reset_status actual=%h required=%h", status, STATUS_RESET);
    end
    compared++;
    if ({byte_valid, byte_data, byte_dc, rd_data} !== 18'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_byte actual=%h required=0", {byte_valid, byte_data, byte_dc, rd_data});
    end
    Reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_init();
    int p0;
    p0 = pulse_cnt;
    send_byte(8'h21, 1'b0);
    send_byte(8'h90, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h0C, 1'b0);
`ifdef PCD8544_RESP_EXT_EN
    exp_vop = 7'h10;
`else
    exp_vop = 7'h00;
`endif
    compared++;
    if (vop !== exp_vop) begin
      mismatched++;
      $display("[TB] FAIL init_vop actual=%h required=%h", vop, exp_vop);
    end
    compared++;
    if ({pd, h_ext, v_mode} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL init_func actual=%b required=000", {pd, h_ext, v_mode});
    end
    compared++;
    if (disp_mode !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL init_disp actual=%b required=10", disp_mode);
    end
    compared++;
    if (pulse_cnt - p0 !== 4) begin
      mismatched++;
      $display("[TB] FAIL init_pulses actual=%0d required=4", pulse_cnt - p0);
    end
    compared++;
    if ({byte_data, byte_dc} !== {8'h0C, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL init_last_byte actual=%h/%b required=0c/0", byte_data, byte_dc);
    end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    int bad;
    for (int i = 0; i < 504; i++) send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    compared++;
    if ({x_addr, y_addr} !== {7'd1, 3'd0}) begin
      mismatched++;
      $display("[TB] FAIL fill_addr actual=x%0d,y%0d required=x1,y0", x_addr, y_addr);
    end
    read_fb(9'd0, d);
    compared++;
    if (d !== 8'h55) begin
      mismatched++;
      $display("[TB] FAIL fill_addr0 actual=%h required=55", d);
    end
    bad = 0;
    for (int a = 1; a < 504; a++) begin
      read_fb(9'(a), d);
      if (d !== 8'hAA) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL fill_aa bad_count actual=%0d required=0", bad);
    end
  endtask

  task automatic test_positioned();
    logic [7:0] d;
    send_byte(8'h8E, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'h1F, 1'b1);
    send_byte(8'h1F, 1'b1);
    read_fb(9'd266, d);
    compared++;
    if (d !== 8'h1F) begin
      mismatched++;
      $display("[TB] FAIL pos_266 actual=%h required=1f", d);
    end
    read_fb(9'd267, d);
    compared++;
    if (d !== 8'h1F) begin
      mismatched++;
      $display("[TB] FAIL pos_267 actual=%h required=1f", d);
    end
    read_fb(9'd268, d);
    compared++;
    if (d !== 8'hAA) begin
      mismatched++;
      $display("[TB] FAIL pos_268 actual=%h required=aa", d);
    end
    compared++;
    if ({x_addr, y_addr} !== {7'd16, 3'd3}) begin
      mismatched++;
      $display("[TB] FAIL pos_addr actual=x%0d,y%0d required=x16,y3", x_addr, y_addr);
    end
  endtask

  task automatic test_vertical_wrap();
    logic [7:0] d;
    send_byte(8'h22, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h45, 1'b0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    read_fb(9'd503, d);
    compared++;
    if (d !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL vert_503 actual=%h required=01", d);
    end
    read_fb(9'd0, d);
    compared++;
    if (d !== 8'h02) begin
      mismatched++;
      $display("[TB] FAIL vert_0 actual=%h required=02", d);
    end
    compared++;
    if ({v_mode, x_addr, y_addr} !== {1'b1, 7'd0, 3'd1}) begin
      mismatched++;
      $display("[TB] FAIL vert_addr actual=v%b,x%0d,y%0d required=v1,x0,y1", v_mode, x_addr, y_addr);
    end
  endtask

  task automatic test_errors_abort();
    int p0;
    p0 = pulse_cnt;
    send_byte(8'hD8, 1'b0);
    compared++;
    if ({x_addr, err_addr} !== {7'd0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL err_setx actual=x%0d,err%b required=x0,err1", x_addr, err_addr);
    end
    send_byte(8'h46, 1'b0);
    compared++;
    if ({y_addr, err_addr} !== {3'd1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL err_sety actual=y%0d,err%b required=y1,err1", y_addr, err_addr);
    end
    sce = 1'b0;
    send_bits(8'hFF, 5, 1'b0);
    sce = 1'b1;
    repeat (8) @(negedge clock);
    send_byte(8'h0D, 1'b0);
    compared++;
    if (disp_mode !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL abort_disp actual=%b required=11", disp_mode);
    end
    compared++;
    if (pulse_cnt - p0 !== 3) begin
      mismatched++;
      $display("[TB] FAIL abort_pulses actual=%0d required=3", pulse_cnt - p0);
    end
  endtask

  task automatic test_lcd_rst();
    logic [7:0] d;
    sce = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (4) @(negedge clock);
    rst = 1'b1;
    repeat (4) @(negedge clock);
    compared++;
    if (status !== STATUS_RESET) begin
      mismatched++;
      $display("[TB] FAIL lcdrst_status actual=%h required=%h", status, STATUS_RESET);
    end
    read_fb(9'd266, d);
    compared++;
    if (d !== 8'h1F) begin
      mismatched++;
      $display("[TB] FAIL lcdrst_fb_kept actual=%h required=1f", d);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    int p0;
    p0 = pulse_cnt;
    sce = 1'b0;
    send_bits(8'h77, 6, 1'b1);
    Reset = 1'b0;
    repeat (3) @(negedge clock);
    sce = 1'b1;
    Reset = 1'b1;
    repeat (6) @(negedge clock);
    compared++;
    if (pulse_cnt - p0 !== 0 || byte_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstabort_valid actual=%0d pulses required=0", pulse_cnt - p0);
    end
    read_fb(9'd0, d);
    compared++;
    if (d !== 8'h02) begin
      mismatched++;
      $display("[TB] FAIL rstabort_fb actual=%h required=02", d);
    end
    compared++;
    if (status !== STATUS_RESET) begin
      mismatched++;
      $display("[TB] FAIL rstabort_status actual=%h required=%h", status, STATUS_RESET);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_fill();
    test_positioned();
    test_vertical_wrap();
    test_errors_abort();
    test_lcd_rst();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
